// File: rtl/frontend_pll_controller.sv
// frontend_pll_controller: settle/sample/adjust loop steering the DCO increment to null the COS product.
// Optional lock detector is compiled in with `FRONTEND_PLL_CTRL_LOCK_DETECT_EN.
module frontend_pll_controller #(
    parameter int PHASE_INCREMENT_BITS = 28,
    parameter int MUL_ACC_WIDTH        = 32,
    parameter int SETTLE_CYCLES        = 256,
    parameter int SETTLE_CNT_BITS      = 16,
    parameter int GAIN_SHIFT           = 8,
    parameter int LOCK_THRESHOLD       = 1024,
    parameter int LOCK_COUNT           = 4
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_ce,
    input  logic                                   i_start,
    input  logic                                   i_stop,
    input  logic        [PHASE_INCREMENT_BITS-1:0] i_initial_phase_increment,
    input  logic        [PHASE_INCREMENT_BITS-1:0] i_min_phase_increment,
    input  logic        [PHASE_INCREMENT_BITS-1:0] i_max_phase_increment,
    input  logic signed [MUL_ACC_WIDTH-1:0]        i_sin_mul_acc,
    input  logic signed [MUL_ACC_WIDTH-1:0]        i_cos_mul_acc,
    output logic        [PHASE_INCREMENT_BITS-1:0] o_phase_increment_out,
    output logic signed [MUL_ACC_WIDTH-1:0]        o_sin_sample,
    output logic signed [MUL_ACC_WIDTH-1:0]        o_cos_sample,
    output logic                                   o_busy,
    output logic                                   o_locked,
    output logic                                   o_out_of_range
);
    localparam int PIB = PHASE_INCREMENT_BITS;
    localparam int MAW = MUL_ACC_WIDTH;
    // Wide enough that the shifted sample plus the increment never overflows,
    // which makes it equivalent to saturating delta before the add.
    localparam int SW = (MAW > PIB ? MAW : PIB) + 2;
    localparam logic [SETTLE_CNT_BITS-1:0] LOAD = SETTLE_CNT_BITS'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADJUST} state_t;
    state_t r_state, w_next;

    logic [SETTLE_CNT_BITS-1:0] r_cnt;
    logic [PIB-1:0]             r_phase, w_init;
    logic signed [MAW-1:0]      r_sin, r_cos;
    logic                       r_oor, w_go, w_busy, w_lo, w_hi;
    logic signed [SW-1:0]       w_cos_ext, w_sum, w_min, w_max;

    assign w_go      = r_state == IDLE && i_start && !i_stop;
    assign w_init    = i_initial_phase_increment < i_min_phase_increment ? i_min_phase_increment :
                       i_initial_phase_increment > i_max_phase_increment ? i_max_phase_increment :
                       i_initial_phase_increment;
    assign w_cos_ext = $signed({{(SW-MAW){r_cos[MAW-1]}}, r_cos});
    assign w_sum     = (w_cos_ext >>> GAIN_SHIFT) + $signed({{(SW-PIB){1'b0}}, r_phase});
    assign w_min     = $signed({{(SW-PIB){1'b0}}, i_min_phase_increment});
    assign w_max     = $signed({{(SW-PIB){1'b0}}, i_max_phase_increment});
    assign w_lo      = w_sum < w_min;
    assign w_hi      = w_sum > w_max;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else if (i_ce) r_state <= w_next;
    end

    always_comb begin
        w_next = i_stop ? IDLE :
                 r_state == IDLE   ? (i_start ? SETTLE : IDLE) :
                 r_state == SETTLE ? (r_cnt == '0 ? SAMPLE : SETTLE) :
                 r_state == SAMPLE ? ADJUST : SETTLE;
    end

    always_comb begin
        w_busy = r_state != IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phase <= '0;
            r_cnt   <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_oor   <= 1'b0;
        end else if (i_ce) begin
            if (w_go) begin
                r_phase <= w_init;
                r_cnt   <= LOAD;
                r_oor   <= 1'b0;
            end else if (!i_stop && r_state == SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - SETTLE_CNT_BITS'(1);
            end else if (!i_stop && r_state == SAMPLE) begin
                r_sin <= i_sin_mul_acc;
                r_cos <= i_cos_mul_acc;
            end else if (!i_stop && r_state == ADJUST) begin
                r_phase <= w_lo ? i_min_phase_increment : w_hi ? i_max_phase_increment : w_sum[PIB-1:0];
                r_oor   <= r_oor | w_lo | w_hi;
                r_cnt   <= LOAD;
            end
        end
    end

`ifdef FRONTEND_PLL_CTRL_LOCK_DETECT_EN
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0] LMAX = LCW'(LOCK_COUNT);
    localparam logic signed [SW-1:0] THR = SW'(LOCK_THRESHOLD);

    logic [LCW-1:0] r_lock_cnt, w_lock_nxt;
    logic           r_locked;

    assign w_lock_nxt = (w_cos_ext < THR && w_cos_ext > -THR) ?
                        (r_lock_cnt == LMAX ? LMAX : r_lock_cnt + LCW'(1)) : '0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (i_ce) begin
            if (w_go) begin
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else if (i_stop) begin
                r_locked <= 1'b0;
            end else if (r_state == ADJUST) begin
                r_lock_cnt <= w_lock_nxt;
                r_locked   <= w_lock_nxt == LMAX;
            end
        end
    end

    assign o_locked = r_locked;
`else
    assign o_locked = 1'b0;
`endif

    assign o_phase_increment_out = r_phase;
    assign o_sin_sample          = r_sin;
    assign o_cos_sample          = r_cos;
    assign o_busy                = w_busy;
    assign o_out_of_range        = r_oor;
endmodule

// File: tb/tb_frontend_pll_controller.sv
// tb_frontend_pll_controller: scenario tasks plus randomized loop checked against an arithmetic model.
module tb_frontend_pll_controller;
    localparam int S = 4, G = 4, THR = 64, LC = 3;
`ifdef FRONTEND_PLL_CTRL_LOCK_DETECT_EN
    localparam bit LD = 1'b1;
`else
    localparam bit LD = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, ce = 1'b0, start = 1'b0, stop = 1'b0;
    logic [27:0] init = '0, mn = '0, mx = '0, out;
    logic signed [31:0] sin = '0, cos = '0, sin_s, cos_s;
    logic busy, locked, oor;
    int checks = 0, failures = 0;
    longint m_out;
    bit m_oor;
    int m_run;

    always #5 clk = ~clk;

    frontend_pll_controller #(
        .PHASE_INCREMENT_BITS(28), .MUL_ACC_WIDTH(32), .SETTLE_CYCLES(S), .SETTLE_CNT_BITS(16),
        .GAIN_SHIFT(G), .LOCK_THRESHOLD(THR), .LOCK_COUNT(LC)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_start(start), .i_stop(stop),
        .i_initial_phase_increment(init), .i_min_phase_increment(mn), .i_max_phase_increment(mx),
        .i_sin_mul_acc(sin), .i_cos_mul_acc(cos),
        .o_phase_increment_out(out), .o_sin_sample(sin_s), .o_cos_sample(cos_s),
        .o_busy(busy), .o_locked(locked), .o_out_of_range(oor)
    );

    task automatic tick(input logic c);
        ce = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        m_out = longint'(init) < longint'(mn) ? longint'(mn) :
                longint'(init) > longint'(mx) ? longint'(mx) : longint'(init);
        m_oor = 1'b0;
        m_run = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1'b1);
        stop = 1'b0;
    endtask

    // One correction: floor(cos / 2^G) added to the current increment, then clamped.
    task automatic model_adjust();
        longint d, q, s;
        d = longint'(1) << G;
        q = longint'(cos) / d;
        if (cos < 0 && longint'(cos) % d != 0) q = q - 1;
        s = m_out + q;
        if (s < longint'(mn)) begin m_out = longint'(mn); m_oor = 1'b1; end
        else if (s > longint'(mx)) begin m_out = longint'(mx); m_oor = 1'b1; end
        else m_out = s;
        m_run = (cos > -THR && cos < THR) ? m_run + 1 : 0;
    endtask

    task automatic run_iter(input string tag, input bit rce);
        int n, guard;
        logic c;
        bit exp_l;
        n = 0;
        guard = 0;
        while (n < S + 2 && guard < 200) begin
            c = rce ? 1'($urandom_range(0, 1)) : 1'b1;
            tick(c);
            if (c) n++;
            guard++;
        end
        model_adjust();
        exp_l = LD && (m_run >= LC);
        checks++;
        if (guard >= 200) begin failures++; $display("FAIL %s_budget got=%0d exp=<200", tag, guard); end
        checks++;
        if (out !== m_out[27:0]) begin failures++; $display("FAIL %s_out got=%0d exp=%0d", tag, out, m_out); end
        checks++;
        if (oor !== m_oor) begin failures++; $display("FAIL %s_oor got=%0b exp=%0b", tag, oor, m_oor); end
        checks++;
        if (locked !== exp_l) begin failures++; $display("FAIL %s_locked got=%0b exp=%0b", tag, locked, exp_l); end
        checks++;
        if (cos_s !== cos || sin_s !== sin || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_sample got=%0d/%0d/%0b exp=%0d/%0d/1", tag, cos_s, sin_s, busy, cos, sin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({out, busy, locked, oor} !== '0) begin
            failures++; $display("FAIL reset_ctrl got=%0d/%0b/%0b/%0b exp=0", out, busy, locked, oor);
        end
        checks++;
        if ({sin_s, cos_s} !== '0) begin
            failures++; $display("FAIL reset_samples got=%0d/%0d exp=0", sin_s, cos_s);
        end
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_track();
        mn = 28'd1000; mx = 28'd100000; init = 28'd50000; cos = 1600; sin = 123;
        do_start();
        checks++;
        if (busy !== 1'b1 || out !== 28'd50000) begin
            failures++; $display("FAIL track_start got=%0b/%0d exp=1/50000", busy, out);
        end
        for (int i = 0; i < S + 1; i++) tick(1'b1);
        checks++;
        if (out !== 28'd50000) begin failures++; $display("FAIL track_early got=%0d exp=50000", out); end
        tick(1'b1);
        model_adjust();
        checks++;
        if (out !== 28'd50100) begin failures++; $display("FAIL track_first got=%0d exp=50100", out); end
        run_iter("track_second", 1'b0);
        checks++;
        if (out !== 28'd50200) begin failures++; $display("FAIL track_50200 got=%0d exp=50200", out); end
    endtask

    task automatic test_clamp();
        do_stop();
        init = 28'd50000; cos = -16000000;
        do_start();
        run_iter("clamp_low", 1'b0);
        cos = 0;
        run_iter("clamp_sticky", 1'b0);
        do_stop();
        do_start();
        checks++;
        if (oor !== 1'b0) begin failures++; $display("FAIL clamp_restart got=%0b exp=0", oor); end
    endtask

    task automatic test_clamp_equal();
        do_stop();
        init = 28'd5;
        do_start();
        checks++;
        if (out !== 28'd1000) begin failures++; $display("FAIL init_low got=%0d exp=1000", out); end
        do_stop();
        init = 28'd200000;
        do_start();
        checks++;
        if (out !== 28'd100000) begin failures++; $display("FAIL init_high got=%0d exp=100000", out); end
        do_stop();
        init = 28'd1100; cos = -1600;
        do_start();
        run_iter("eq_min", 1'b0);
        do_stop();
        init = 28'd99900; cos = 1600;
        do_start();
        run_iter("eq_max", 1'b0);
        cos = 16;
        run_iter("over_max", 1'b0);
    endtask

    task automatic test_lock();
        do_stop();
        init = 28'd50000;
        do_start();
        cos = 10;
        for (int i = 0; i < 3; i++) run_iter("lock_in", 1'b0);
        cos = -63;
        run_iter("lock_neg", 1'b0);
        cos = 64;
        run_iter("lock_lost", 1'b0);
        cos = -10;
        for (int i = 0; i < 3; i++) run_iter("lock_again", 1'b0);
        do_stop();
        checks++;
        if (locked !== 1'b0 || busy !== 1'b0 || out !== m_out[27:0]) begin
            failures++; $display("FAIL stop_clears got=%0b/%0b/%0d exp=0/0/%0d", locked, busy, out, m_out);
        end
    endtask

    task automatic test_ce_toggle();
        do_stop();
        init = 28'd50000; cos = 1600;
        do_start();
        for (int i = 1; i < 12; i++) tick(1'(i % 2 == 0));
        checks++;
        if (out !== 28'd50000) begin failures++; $display("FAIL ce_early got=%0d exp=50000", out); end
        tick(1'b1);
        checks++;
        if (out !== 28'd50100) begin failures++; $display("FAIL ce_update got=%0d exp=50100", out); end
    endtask

    task automatic test_back_to_back();
        do_stop();
        init = 28'd50000; cos = 1600;
        do_start();
        init = 28'd70000;
        start = 1'b1;
        for (int i = 0; i < S + 1; i++) tick(1'b1);
        start = 1'b0;
        tick(1'b1);
        checks++;
        if (out !== 28'd50100) begin failures++; $display("FAIL start_busy got=%0d exp=50100", out); end
        init = 28'd50000;
        do_stop();
        do_start();
        tick(1'b1);
        tick(1'b1);
        stop = 1'b1;
        tick(1'b1);
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== 28'd50000) begin
            failures++; $display("FAIL stop_settle got=%0b/%0d exp=0/50000", busy, out);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        tick(1'b1);
        tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out, busy, locked, oor, sin_s, cos_s} !== '0) begin
            failures++; $display("FAIL reset_mid got=%0d/%0b/%0d/%0d exp=0", out, busy, sin_s, cos_s);
        end
        tick(1'b1);
        rst = 1'b0;
        stop = 1'b1; start = 1'b1;
        tick(1'b1);
        stop = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || out !== 28'd0) begin
            failures++; $display("FAIL stop_start got=%0b/%0d exp=0/0", busy, out);
        end
    endtask

    task automatic test_random();
        int unsigned a, b;
        for (int t = 0; t < 8; t++) begin
            do_stop();
            a = $urandom_range(0, 28'hFFFFFFF);
            b = $urandom_range(0, 28'hFFFFFFF);
            mn = 28'(a < b ? a : b);
            mx = 28'(a < b ? b : a);
            init = 28'($urandom_range(0, 28'hFFFFFFF));
            do_start();
            checks++;
            if (out !== m_out[27:0]) begin failures++; $display("FAIL rand_init got=%0d exp=%0d", out, m_out); end
            for (int k = 0; k < 5; k++) begin
                case ($urandom_range(0, 2))
                    0: cos = int'($urandom_range(0, 200)) - 100;
                    1: cos = int'($urandom_range(0, 2097152)) - 1048576;
                    default: cos = $signed($urandom());
                endcase
                sin = $signed($urandom());
                run_iter("rand", 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_track();
        test_clamp();
        test_clamp_equal();
        test_lock();
        test_ce_toggle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
